// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       retire;
  logic       illegal;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  // Datapath side: supplies instruction fields and flags, consumes controls.
  modport master (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, retire, illegal, alusrcb, pcsrc, alucontrol, state
  );

  // Controller side.
  modport slave (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, retire, illegal, alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: Moore FSM plus ALU decoder.
module mc_controller (
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;

  // State and illegal-flag registers; reset overrides any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d        = S_FETCH;
    illegal_d      = 1'b0;
    aluop          = 2'b00;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.iord       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.retire     = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = 3'b010;

    case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        bus.alusrcb  = 2'b01;
        bus.irwrite  = 1'b1;
        pcwrite      = 1'b1;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        state_d  = S_MEMWB;
        bus.iord = 1'b1;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      S_EXECUTE: begin
        state_d     = S_ALUWB;
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
        bus.retire  = 1'b1;
      end
      S_ADDIEX: begin
        state_d     = S_ADDIWB;
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      S_JUMP: begin
        bus.pcsrc  = 2'b10;
        pcwrite    = 1'b1;
        bus.retire = 1'b1;
      end
      default: begin
        // Unused codes 12-15: everything low, recover to FETCH.
        bus.alucontrol = 3'b000;
      end
    endcase

    // ALU decoder: memory/PC math adds, branch compares, R-type follows funct.
    case (aluop)
      2'b01: bus.alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      default: ;
    endcase
  end

  // PC enable is the only output that also depends on a live input.
  assign bus.pcen    = pcwrite | (branch & bus.zero);
  assign bus.illegal = illegal_q;
  assign bus.state   = 4'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Randomised self-checking bench for mc_controller against an instruction-level model.
module tb_mc_controller;

  logic clk;
  logic reset;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: current state code, remaining path of the instruction in flight.
  int m_state   = 0;
  int m_path[$];
  bit m_illegal = 1'b0;
  bit chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // State path followed from FETCH, by opcode (length = cycles back to FETCH).
  task automatic push_path(input logic [5:0] op);
    case (op)
      6'b100011: m_path = '{1, 2, 3, 4, 0};
      6'b101011: m_path = '{1, 2, 5, 0};
      6'b000000: m_path = '{1, 6, 7, 0};
      6'b001000: m_path = '{1, 9, 10, 0};
      6'b000100: m_path = '{1, 8, 0};
      6'b000010: m_path = '{1, 11, 0};
      default:   m_path = '{1, 0};
    endcase
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control word {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,retire,alusrcb,pcsrc,alucontrol}.
  function automatic logic [15:0] exp_vec(input int s, input logic [5:0] f, input logic z);
    logic pcen, mw, irw, rw, asa, iord, m2r, rdst, ret;
    logic [1:0] asb, psrc;
    logic [2:0] alu;
    {pcen, mw, irw, rw, asa, iord, m2r, rdst, ret} = '0;
    asb = 2'b00; psrc = 2'b00; alu = 3'b010;
    case (s)
      0:  begin pcen = 1; irw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; ret = 1; end
      5:  begin iord = 1; mw = 1; ret = 1; end
      6:  begin asa = 1; alu = funct_alu(f); end
      7:  begin rdst = 1; rw = 1; ret = 1; end
      8:  begin asa = 1; psrc = 2'b01; pcen = z; ret = 1; alu = 3'b110; end
      10: begin rw = 1; ret = 1; end
      11: begin psrc = 2'b10; pcen = 1; ret = 1; end
      default: alu = 3'b000;
    endcase
    return {pcen, mw, irw, rw, asa, iord, m2r, rdst, ret, asb, psrc, alu};
  endfunction

  function automatic bit op_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Model advance on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_state   = 0;
      m_path    = {};
      m_illegal = 1'b0;
      chk_en    = 1'b1;
    end else begin
      m_illegal = (m_state == 1) && !op_legal(bus.op);
      if (m_path.size() == 0) push_path(bus.op);
      m_state = m_path.pop_front();
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", 32'({bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca,
                         bus.iord, bus.memtoreg, bus.regdst, bus.retire, bus.alusrcb,
                         bus.pcsrc, bus.alucontrol}),
            32'(exp_vec(m_state, bus.funct, bus.zero)));
      check("state", 32'(bus.state), 32'(m_state));
      check("illegal", 32'(bus.illegal), 32'(m_illegal));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int lw_seq[6];
  int retires;
  int rtype_f[6];
  int rtype_a[6];
  bit reached;

  initial begin
    reset = 1'b1; bus.op = 6'h3f; bus.funct = 6'h00; bus.zero = 1'b0;
    lw_seq  = '{0, 1, 2, 3, 4, 0};
    rtype_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    rtype_a = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    tick(); tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_irwrite", 32'(bus.irwrite), 32'd1);
    check("rst_alusrcb", 32'(bus.alusrcb), 32'd1);
    reset = 1'b0;
    bus.op = 6'b100011;

    // lw sequence with single retire in state 4.
    retires = 0;
    for (int i = 0; i < 6; i++) begin
      check("lw_seq", 32'(bus.state), 32'(lw_seq[i]));
      if (bus.retire) retires++;
      if (bus.regwrite) check("lw_regwrite_state", 32'(bus.state), 32'd4);
      if (i < 5) tick();
    end
    check("lw_retires", 32'(retires), 32'd1);

    // beq taken then not taken.
    bus.op = 6'b000100; bus.zero = 1'b1;
    tick(); tick();
    check("beq_state", 32'(bus.state), 32'd8);
    check("beq_pcen1", 32'(bus.pcen), 32'd1);
    check("beq_pcsrc", 32'(bus.pcsrc), 32'd1);
    check("beq_alu", 32'(bus.alucontrol), 32'd6);
    bus.zero = 1'b0; #1;
    check("beq_pcen0", 32'(bus.pcen), 32'd0);
    tick();
    check("beq_back", 32'(bus.state), 32'd0);

    // R-type funct sweep.
    bus.op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      bus.funct = 6'(rtype_f[k]);
      tick(); tick();
      check("r_exec_state", 32'(bus.state), 32'd6);
      check("r_alu", 32'(bus.alucontrol), 32'(rtype_a[k]));
      check("r_alusrcb", 32'(bus.alusrcb), 32'd0);
      tick();
      check("r_wb_regdst", 32'(bus.regdst), 32'd1);
      check("r_wb_regwrite", 32'(bus.regwrite), 32'd1);
      tick();
    end

    // Illegal op.
    bus.op = 6'b111111;
    tick();
    check("ill_decode", 32'(bus.state), 32'd1);
    tick();
    check("ill_state", 32'(bus.state), 32'd0);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    check("ill_retire", 32'(bus.retire), 32'd0);

    // Jump.
    bus.op = 6'b000010;
    tick();
    check("ill_clear", 32'(bus.illegal), 32'd0);
    tick();
    check("j_state", 32'(bus.state), 32'd11);
    check("j_pcen", 32'(bus.pcen), 32'd1);
    check("j_pcsrc", 32'(bus.pcsrc), 32'd2);
    tick();
    check("j_back", 32'(bus.state), 32'd0);

    // sw store strobe.
    bus.op = 6'b101011;
    tick(); tick(); tick();
    check("sw_state", 32'(bus.state), 32'd5);
    check("sw_memwrite", 32'(bus.memwrite), 32'd1);
    check("sw_iord", 32'(bus.iord), 32'd1);
    tick();

    // Reset in the middle of a load.
    bus.op = 6'b100011;
    tick(); tick(); tick();
    check("mid_memrd", 32'(bus.state), 32'd3);
    reset = 1'b1;
    tick();
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_regwrite", 32'(bus.regwrite), 32'd0);
    reset = 1'b0;
    tick();
    check("mid_refetch", 32'(bus.state), 32'd1);
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      if (bus.state == 4'd0) reached = 1'b1;
    end
    check("mid_return", 32'(reached), 32'd1);

    // Random instruction stream; op/funct only change while in FETCH.
    for (int c = 0; c < 4000; c++) begin
      bus.zero = 1'($urandom_range(0, 1));
      if (m_state == 0) begin
        case ($urandom_range(0, 7))
          0: bus.op = 6'b100011;
          1: bus.op = 6'b101011;
          2: bus.op = 6'b000000;
          3: bus.op = 6'b000100;
          4: bus.op = 6'b001000;
          5: bus.op = 6'b000010;
          default: bus.op = 6'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) bus.funct = 6'($urandom);
        else bus.funct = 6'(rtype_f[$urandom_range(0, 4)]);
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter NONE; the block has no parameters, and all encodings are fixed by this document.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 op  in  6  instr[31:26] from the instruction register.
REQ-005 funct  in  6  instr[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag from the datapath.
REQ-007 Single-bit outputs SHALL be: pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, retire, illegal.
REQ-008 Two-bit outputs SHALL be: alusrcb (00 reg B, 01 const 4, 10 signimm, 11 signimm<<2) and pcsrc (00 aluresult, 01 aluout, 10 jump target).
REQ-009 alucontrol  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 state  out  4  current FSM state code, for debug.

Function
REQ-011 The FSM SHALL use these state codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-012 FETCH SHALL always go to DECODE.
REQ-013 DECODE SHALL branch on op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other op -> FETCH
REQ-014 MEMADR SHALL go to MEMRD when op=100011 and to MEMWR otherwise.
REQ-015 Remaining transitions SHALL be: MEMRD->MEMWB, EXECUTE->ALUWB, ADDIEX->ADDIWB. MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP SHALL each go to FETCH.
REQ-016 State codes 12-15 SHALL go to FETCH on the next edge; all outputs SHALL be 0 while in them.
REQ-017 Every output not listed for the current state SHALL be 0. Outputs SHALL be decoded from state combinationally (Moore), except pcen.
REQ-018 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-019 DECODE: alusrca=0, alusrcb=11, aluop=00.
REQ-020 MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-021 MEMRD: iord=1. MEMWR: iord=1, memwrite=1.
REQ-022 MEMWB: regdst=0, memtoreg=1, regwrite=1.
REQ-023 EXECUTE: alusrca=1, alusrcb=00, aluop=10. ALUWB: regdst=1, memtoreg=0, regwrite=1.
REQ-024 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. JUMP: pcsrc=10, pcwrite=1.
REQ-025 ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-026 pcen SHALL equal pcwrite OR (branch AND zero), combinational from the current zero input.
REQ-027 alucontrol SHALL be 010 when aluop=00 and 110 when aluop=01.
REQ-028 When aluop=10, alucontrol SHALL follow funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other->010.
REQ-029 retire SHALL be 1 for exactly one cycle, in the final state of each legal instruction: MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
REQ-030 illegal SHALL be registered: 1 for the single cycle following a DECODE with an unlisted op, otherwise 0.
REQ-031 Latency in cycles, FETCH to return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-032 op and funct are not latched internally; the datapath's instruction register SHALL hold them stable from DECODE until the instruction retires.

Reset
REQ-033 reset=1 at a rising edge SHALL force state=FETCH and illegal=0, overriding any transition, including mid-instruction.
REQ-034 While reset is held, the FETCH outputs SHALL be driven; the datapath PC register gates them with its own reset.
REQ-035 On the first edge after reset deasserts, state SHALL go FETCH->DECODE.
REQ-036 No register SHALL have a reset value other than 0; the block SHALL have no asynchronous paths.

Verification
REQ-037 Reset then op=100011 held: state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4; retire pulses once, in state 4.
REQ-038 op=000100, zero=1: in state 8, pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0: pcen=0 in state 8, and the block returns to FETCH after 3 cycles.
REQ-039 op=000000, funct=100010: state 6 gives alucontrol=110 and alusrcb=00; state 7 gives regdst=1 and regwrite=1. Sweep the five funct codes plus 111111; the last gives 010.
REQ-040 op=111111: state sequence 0,1,0; illegal=1 in the second FETCH; retire never asserts; memwrite and regwrite stay 0.
REQ-041 Assert reset during MEMRD (state 3) of a lw: the next state is 0, no regwrite occurs, and a normal fetch follows.
REQ-042 op=000010: state sequence 0,1,11,0; in state 11, pcen=1 and pcsrc=10. For op=101011: memwrite=1 and iord=1 only in state 5.
